// File: rtl/rail_pkg.sv
// Shared state encodings, weather codes and vote thresholds for the level-crossing controllers.
package rail_pkg;

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WARN     = 3'd1;
   localparam logic [2:0] LOWERING = 3'd2;
   localparam logic [2:0] CLOSED   = 3'd3;
   localparam logic [2:0] CLEARING = 3'd4;
   localparam logic [2:0] RAISING  = 3'd5;

   localparam logic [1:0] WX_CLEAR     = 2'b00;
   localparam logic [1:0] WX_RAIN      = 2'b01;
   localparam logic [1:0] WX_STORM     = 2'b10;
   localparam logic [1:0] WX_STORM_FOG = 2'b11;

   // In storm weather a single sensor is trusted; otherwise two must agree.
   localparam logic [1:0] THR_NORMAL = 2'd2;
   localparam logic [1:0] THR_STORM  = 2'd1;

   function automatic logic [1:0] popcount3(input logic [2:0] bits);
      return {1'b0, bits[0]} + {1'b0, bits[1]} + {1'b0, bits[2]};
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stability filter: the output follows the
// synced input only after DEBOUNCE_CYC consecutive equal samples.
module sensor_debounce #(
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic filt
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // Synchronise, then count consecutive samples that differ from the filtered value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         filt  <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         if (sync2 == filt) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
            filt <= sync2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/crossing_gate_fsm.sv
// Single level-crossing gate controller: sensor voting, warn/lower/hold/clear/raise
// sequencing, persistent sensor-disagreement flag and a saturating passage counter.
module crossing_gate_fsm
   import rail_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 4,
   parameter int WARN_CYC     = 50,
   parameter int LOWER_CYC    = 100,
   parameter int CLEAR_CYC    = 50,
   parameter int RAISE_CYC    = 100,
   parameter int FAULT_CYC    = 200,
   parameter int TIMER_W      = 16
) (
   input  logic       clk_50mhz,
   input  logic       rst_n,
   input  logic       ir_sensor,
   input  logic       vib_sensor,
   input  logic       rfid_valid,
   input  logic       emergency,
   input  logic [1:0] weather_mode,
   output logic       barrier_down,
   output logic       red_light,
   output logic       yellow_light,
   output logic       alarm_sound,
   output logic [2:0] state_out,
   output logic       sensor_fault,
   output logic [7:0] train_count
);

   localparam logic [TIMER_W-1:0] WARN_T   = TIMER_W'(WARN_CYC);
   localparam logic [TIMER_W-1:0] WARN_T2  = TIMER_W'(2 * WARN_CYC);
   localparam logic [TIMER_W-1:0] LOWER_T  = TIMER_W'(LOWER_CYC);
   localparam logic [TIMER_W-1:0] CLEAR_T  = TIMER_W'(CLEAR_CYC);
   localparam logic [TIMER_W-1:0] RAISE_T  = TIMER_W'(RAISE_CYC);
   localparam logic [TIMER_W-1:0] TIMER_1  = TIMER_W'(1);
   localparam int                 FC_W     = $clog2(FAULT_CYC + 1);

   logic [2:0]         filt_bits;
   logic               em_sync1;
   logic               em_sync2;
   logic               occupied;
   logic [2:0]         state;
   logic [2:0]         state_nx;
   logic [TIMER_W-1:0] timer;
   logic [TIMER_W-1:0] timer_nx;
   logic [TIMER_W-1:0] warn_load;
   logic               count_inc;
   logic [FC_W-1:0]    fault_cnt;
   logic               sensors_agree;

   sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ir   (.clk(clk_50mhz), .rst_n(rst_n), .din(ir_sensor),  .filt(filt_bits[0]));
   sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_vib  (.clk(clk_50mhz), .rst_n(rst_n), .din(vib_sensor), .filt(filt_bits[1]));
   sensor_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_rfid (.clk(clk_50mhz), .rst_n(rst_n), .din(rfid_valid), .filt(filt_bits[2]));

   assign occupied      = popcount3(filt_bits) >= (weather_mode[1] ? THR_STORM : THR_NORMAL);
   assign warn_load     = (weather_mode != WX_CLEAR) ? WARN_T2 : WARN_T;
   assign sensors_agree = (&filt_bits) | ~(|filt_bits);
   assign state_out     = state;

   // Next-state and phase-timer logic; emergency is checked before occupancy everywhere.
   always_comb begin
      state_nx  = state;
      timer_nx  = (timer != '0) ? timer - TIMER_1 : '0;
      count_inc = 1'b0;
      case (state)
         IDLE: begin
            if (em_sync2) begin
               state_nx = LOWERING; timer_nx = LOWER_T;
            end else if (occupied) begin
               state_nx = WARN;     timer_nx = warn_load;
            end else begin
               state_nx = IDLE;
            end
         end
         WARN: begin
            if (em_sync2 || timer == TIMER_1) begin
               state_nx = LOWERING; timer_nx = LOWER_T;
            end else begin
               state_nx = WARN;
            end
         end
         LOWERING: begin
            if (timer == TIMER_1) begin
               state_nx = CLOSED;   timer_nx = '0;
            end else begin
               state_nx = LOWERING;
            end
         end
         CLOSED: begin
            if (!occupied && !em_sync2) begin
               state_nx = CLEARING; timer_nx = CLEAR_T;
            end else begin
               state_nx = CLOSED;
            end
         end
         CLEARING: begin
            if (occupied || em_sync2) begin
               state_nx = CLOSED;   timer_nx = '0;
            end else if (timer == TIMER_1) begin
               state_nx = RAISING;  timer_nx = RAISE_T; count_inc = 1'b1;
            end else begin
               state_nx = CLEARING;
            end
         end
         RAISING: begin
            if (occupied || em_sync2) begin
               state_nx = LOWERING; timer_nx = LOWER_T;
            end else if (timer == TIMER_1) begin
               state_nx = IDLE;     timer_nx = '0;
            end else begin
               state_nx = RAISING;
            end
         end
         default: begin
            state_nx = LOWERING; timer_nx = LOWER_T;
         end
      endcase
   end

   // State, timer, emergency synchroniser and passage counter.
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         timer       <= '0;
         em_sync1    <= 1'b0;
         em_sync2    <= 1'b0;
         train_count <= 8'd0;
      end else begin
         state    <= state_nx;
         timer    <= timer_nx;
         em_sync1 <= emergency;
         em_sync2 <= em_sync1;
         if (count_inc && train_count != 8'hFF) begin
            train_count <= train_count + 8'd1;
         end
      end
   end

   // Disagreement persistence counter; the flag drops on the cycle after the sensors agree.
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         fault_cnt    <= '0;
         sensor_fault <= 1'b0;
      end else if (sensors_agree) begin
         fault_cnt    <= '0;
         sensor_fault <= 1'b0;
      end else begin
         if (fault_cnt != FC_W'(FAULT_CYC)) begin
            fault_cnt <= fault_cnt + FC_W'(1);
         end
         sensor_fault <= (fault_cnt >= FC_W'(FAULT_CYC - 1));
      end
   end

   // Lamp, alarm and barrier decode of the current state.
   always_comb begin
      barrier_down = 1'b0;
      red_light    = 1'b0;
      yellow_light = 1'b0;
      alarm_sound  = 1'b0;
      case (state)
         IDLE:     begin end
         WARN:     begin yellow_light = 1'b1; alarm_sound = 1'b1; end
         LOWERING: begin red_light = 1'b1; alarm_sound = 1'b1; barrier_down = 1'b1; end
         CLOSED:   begin red_light = 1'b1; alarm_sound = 1'b1; barrier_down = 1'b1; end
         CLEARING: begin red_light = 1'b1; barrier_down = 1'b1; end
         RAISING:  begin yellow_light = 1'b1; end
         default:  begin red_light = 1'b1; alarm_sound = 1'b1; barrier_down = 1'b1; end
      endcase
   end

endmodule

// File: doc/crossing_gate_fsm.md
Name: crossing_gate_fsm

Overview:
Per-crossing gate controller that consumes the trackside sensor interface (IR, vibration, RFID), emergency and weather inputs, and drives the barrier, lights and alarm for one level crossing. It synchronises, debounces and votes the three sensors, then sequences warn, lower, hold, clear and raise. Four instances sit inside the system top, one per crossing.

Parameters:
DEBOUNCE_CYC, 4, consecutive stable cycles required before a synced sensor bit updates its filtered value
WARN_CYC, 50, yellow/alarm pre-warning duration; doubled when weather_mode != 0
LOWER_CYC, 100, barrier lowering travel time
CLEAR_CYC, 50, continuous unoccupied cycles required before raising
RAISE_CYC, 100, barrier raising travel time
FAULT_CYC, 200, sensor-disagreement persistence before sensor_fault asserts
TIMER_W, 16, phase timer width; must satisfy 2*WARN_CYC < 2^TIMER_W

Ports:
clk_50mhz  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ir_sensor  in  1  IR beam broken (async)
vib_sensor  in  1  rail vibration detected (async)
rfid_valid  in  1  valid train tag read (async)
emergency  in  1  global emergency close (async)
weather_mode  in  2  00 clear, 01 rain, 10 storm, 11 storm+fog; quasi-static
barrier_down  out  1  barrier commanded down
red_light  out  1  red lamp
yellow_light  out  1  yellow lamp
alarm_sound  out  1  audible alarm
state_out  out  3  current state encoding
sensor_fault  out  1  filtered sensors disagree persistently
train_count  out  8  completed passages, saturating

Behaviour:
- Reset is asynchronous and active-low: rst_n low forces state IDLE, all outputs 0, train_count 0, timers 0, sync flops and filtered bits 0. Reset mid-operation raises the barrier immediately. This is intended.
- ir_sensor, vib_sensor, rfid_valid and emergency each pass through a 2-flop synchroniser.
- Only the three sensors are debounced. A filtered bit takes the new value after DEBOUNCE_CYC consecutive equal synced samples. Any glitch restarts the count.
- Vote: occupied = (popcount of filtered bits >= thr). thr = 1 when weather_mode[1] is set, otherwise thr = 2.
- Latency:
  - Sensor edge held steady to state change: DEBOUNCE_CYC+3 cycles (7 at default).
  - emergency edge to state change: 3 cycles.
- Outputs are a pure decode of the state register and add no latency.
- States and encodings (state_out): IDLE=0, WARN=1, LOWERING=2, CLOSED=3, CLEARING=4, RAISING=5. Codes 6 and 7 recover to LOWERING.
  - IDLE: all outputs 0. occupied goes to WARN. emergency goes to LOWERING and has priority.
  - WARN: yellow=1, alarm=1. The timer expires after WARN_CYC cycles, or 2*WARN_CYC if weather_mode != 0, then goes to LOWERING. emergency goes to LOWERING immediately.
  - LOWERING: red=1, alarm=1, barrier_down=1. Goes to CLOSED after LOWER_CYC cycles. No early exit.
  - CLOSED: red=1, alarm=1, barrier_down=1. (!occupied && !emergency) goes to CLEARING.
  - CLEARING: red=1, barrier_down=1, alarm=0. occupied or emergency goes back to CLOSED and the timer reloads. CLEAR_CYC unoccupied cycles go to RAISING, and train_count increments on that transition, saturating at 255.
  - RAISING: yellow=1, all other outputs 0. occupied or emergency goes to LOWERING next cycle, a safety re-lower. Goes to IDLE after RAISE_CYC cycles.
- Timer: loads on every state entry, counts down, and "expires" on the cycle it reads 1, so a phase lasts exactly N cycles.
- sensor_fault: a FAULT_CYC-cycle counter runs while the filtered bits are not all equal and resets when they agree. The output is registered. It asserts when the counter reaches FAULT_CYC and deasserts the cycle after agreement. sensor_fault does not affect state transitions.
- Simultaneous occupied and emergency: emergency path wins.

Decomposition:
- Shared package rail_pkg holds:
  - state localparams (IDLE..RAISING, 3-bit)
  - weather codes (WX_CLEAR=00, WX_RAIN=01, WX_STORM=10, WX_STORM_FOG=11)
  - vote thresholds
- One sub-module, sensor_debounce (parameter DEBOUNCE_CYC): 2-flop sync plus stability counter, one bit in and one filtered bit out. It is instantiated three times.
- The emergency synchroniser is inline.

Test Plan:
1. Normal passage, weather 00: all three sensors go to 1 at cycle 0 and are held for 500 cycles.
   -> WARN at cycle 7, LOWERING at 57, CLOSED at 157.
   -> Sensors go to 0 at cycle 500: CLEARING at 507, RAISING at 557, IDLE at 657.
   -> train_count=1, all outputs 0 at end.
2. Storm redundancy: weather 10, IR stuck 0, only rfid_valid=1.
   -> WARN at cycle 7, warn lasts 100 cycles.
   -> Same stimulus with weather 00 stays IDLE, and sensor_fault asserts at cycle 2+DEBOUNCE_CYC+200 ±1.
3. Emergency from IDLE: pulse emergency high.
   -> state LOWERING 3 cycles later, barrier_down=1.
   -> After release and LOWER_CYC, CLOSED then CLEARING, then back to IDLE after 150 more cycles.
4. Re-occupation: sensors re-assert 20 cycles into CLEARING -> returns to CLOSED and train_count is unchanged. Sensors re-assert 30 cycles into RAISING -> LOWERING, and barrier_down=1 at state entry.
5. Glitch rejection: IR and vib pulse high for 3 cycles (< DEBOUNCE_CYC) -> state stays IDLE and filtered bits never change.
6. Reset mid-CLOSED: rst_n low asynchronously -> outputs 0 and state_out=0 without waiting for a clock edge. After release with no sensors active, state stays IDLE and train_count=0.
